// File: rtl/sequence_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM encodings,
// default widths and the frame-length clamp.
package sequence_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN    = 16;
  localparam int DEF_LEN_W      = 5;
  localparam int DEF_REP_W      = 4;
  localparam int DEF_GAP_CYCLES = 0;

  // Requested lengths beyond the pattern register collapse to its full width.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; it stops at zero instead of wrapping.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority over decrement; decrement is held off at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sequence_pattern_gen.sv
// Serial pattern transmitter: latches a word on a load handshake and shifts it
// out MSB-first, repeating with optional idle gaps and pulsing done at the end.
module sequence_pattern_gen
  import sequence_gen_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int REP_W      = DEF_REP_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [REP_W-1:0]   load_rep,
  input  logic               abort,
  output logic               out,
  output logic               out_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               done
);

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_q, out_d, vld_q, vld_d, fs_q, fs_d, done_q, done_d, busy_q;

  logic [LEN_W-1:0] len_eff, bit_val, bit_cnt;
  logic             bit_load, bit_dec, bit_zero;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_load, rep_dec, rep_zero;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_load, gap_dec, gap_zero;
  logic [MAX_LEN-1:0] new_sh, cur_sh, restart_sh;
  logic             unused_cnt;

  assign len_eff    = LEN_W'(clamp_len(int'(load_len), MAX_LEN));
  // Word shifted so that bit 0 is the bit to emit next cycle.
  assign new_sh     = load_data >> (len_eff - LEN_W'(1));
  assign cur_sh     = data_q >> (bit_cnt - LEN_W'(1));
  assign restart_sh = data_q >> (len_q - LEN_W'(1));
  // Repeat and gap counts are only consulted through their zero flags.
  assign unused_cnt = ^{rep_cnt, gap_cnt};

  seq_down_counter #(.W(LEN_W)) u_bit_cnt (
    .clk(clk), .rst(rst), .load_i(bit_load), .val_i(bit_val),
    .dec_i(bit_dec), .cnt_o(bit_cnt), .zero_o(bit_zero)
  );

  seq_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk(clk), .rst(rst), .load_i(rep_load), .val_i(load_rep),
    .dec_i(rep_dec), .cnt_o(rep_cnt), .zero_o(rep_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .load_i(gap_load), .val_i(GAP_W'(GAP_CYCLES - 1)),
    .dec_i(gap_dec), .cnt_o(gap_cnt), .zero_o(gap_zero)
  );

  // Next-state and next-output logic; outputs describe the coming cycle.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    out_d    = 1'b0;
    vld_d    = 1'b0;
    fs_d     = 1'b0;
    done_d   = 1'b0;
    bit_load = 1'b0;
    bit_val  = len_q - LEN_W'(1);
    bit_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          data_d = load_data;
          len_d  = len_eff;
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = SHIFT;
            out_d    = new_sh[0];
            vld_d    = 1'b1;
            fs_d     = 1'b1;
            bit_load = 1'b1;
            bit_val  = len_eff - LEN_W'(1);
            rep_load = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!bit_zero) begin
          bit_dec = 1'b1;
          out_d   = cur_sh[0];
          vld_d   = 1'b1;
        end else if (!rep_zero) begin
          rep_dec = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d  = GAP;
            gap_load = 1'b1;
          end else begin
            out_d    = restart_sh[0];
            vld_d    = 1'b1;
            fs_d     = 1'b1;
            bit_load = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_zero) begin
          state_d  = SHIFT;
          out_d    = restart_sh[0];
          vld_d    = 1'b1;
          fs_d     = 1'b1;
          bit_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pattern and registered outputs; reset cancels everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign out         = out_q;
  assign out_valid   = vld_q;
  assign frame_start = fs_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sequence_pattern_gen.sv
// Bench for sequence_pattern_gen: one back-to-back instance and one with a
// two-cycle gap; per-cycle expectations flow through a queue.
module tb_sequence_pattern_gen;

  logic        clk = 1'b0;
  logic        rst, lv0, lv1, abort;
  logic [15:0] ld;
  logic [4:0]  ll;
  logic [3:0]  lr;
  logic        rdy0, o0, ov0, fs0, b0, d0;
  logic        rdy1, o1, ov1, fs1, b1, d1;

  int          checks = 0;
  int          failures = 0;
  int          dut_sel = 0;
  string       cur_name = "init";
  logic [5:0]  expq[$];

  // Vector fields: {out, out_valid, frame_start, done, busy, load_ready}
  localparam logic [5:0] IDLE_E = 6'b000001;
  localparam logic [5:0] DONE_E = 6'b000101;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  len;
    logic [3:0]  rep;
    int          nbits;
    int          flen;
    logic [63:0] stream;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  sequence_pattern_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0), .load_data(ld),
    .load_len(ll), .load_rep(lr), .abort(abort), .out(o0), .out_valid(ov0),
    .frame_start(fs0), .busy(b0), .done(d0)
  );

  sequence_pattern_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .load_data(ld),
    .load_len(ll), .load_rep(lr), .abort(abort), .out(o1), .out_valid(ov1),
    .frame_start(fs1), .busy(b1), .done(d1)
  );

  function automatic logic [5:0] sample();
    if (dut_sel == 1) return {o1, ov1, fs1, d1, b1, rdy1};
    return {o0, ov0, fs0, d0, b0, rdy0};
  endfunction

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (out,valid,fstart,done,busy,ready)", nm, act, exp);
    end
  endtask

  task automatic step();
    logic [5:0] e;
    @(negedge clk);
    lv0 = 1'b0;
    lv1 = 1'b0;
    abort = 1'b0;
    e = expq.pop_front();
    check(cur_name, sample(), e);
  endtask

  task automatic drain();
    while (expq.size() > 0) step();
  endtask

  task automatic start(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r);
    logic [5:0] s;
    s = sample();
    check({cur_name, "_ready"}, {5'b0, s[0]}, 6'b000001);
    ld = d;
    ll = l;
    lr = r;
    if (dut_sel == 1) lv1 = 1'b1;
    else lv0 = 1'b1;
  endtask

  task automatic push_bits(input logic [63:0] stream, input int nbits, input int flen,
                           input bit add_done, input bit add_idle);
    for (int k = 0; k < nbits; k++) begin
      expq.push_back({stream[nbits-1-k], 1'b1, (k % flen) == 0, 1'b0, 1'b1, 1'b0});
    end
    if (add_done) expq.push_back(DONE_E);
    if (add_idle) expq.push_back(IDLE_E);
  endtask

  initial begin
    logic [12:0] g_o, g_v, g_f;
    tbl[0] = '{16'h00B5, 5'd8,  4'd0, 8,  8,  64'hB5};
    tbl[1] = '{16'h0005, 5'd3,  4'd1, 6,  3,  64'h2D};
    tbl[2] = '{16'hFFFF, 5'd0,  4'd3, 0,  0,  64'h0};
    tbl[3] = '{16'hABCD, 5'd20, 4'd0, 16, 16, 64'hABCD};
    tbl[4] = '{16'h0001, 5'd1,  4'd2, 3,  1,  64'h7};
    tbl[5] = '{16'h1236, 5'd4,  4'd0, 4,  4,  64'h6};

    rst = 1'b1; lv0 = 1'b0; lv1 = 1'b0; abort = 1'b0; ld = '0; ll = '0; lr = '0;
    repeat (2) @(negedge clk);
    cur_name = "reset";
    dut_sel = 0; check(cur_name, sample(), IDLE_E);
    dut_sel = 1; check(cur_name, sample(), IDLE_E);
    dut_sel = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cur_name = $sformatf("vec%0d", i);
      start(tbl[i].data, tbl[i].len, tbl[i].rep);
      push_bits(tbl[i].stream, tbl[i].nbits, tbl[i].flen, 1'b1, 1'b1);
      drain();
    end

    // Three frames of 101 separated by two idle cycles
    cur_name = "gap";
    dut_sel = 1;
    g_o = 13'b1010010100101;
    g_v = 13'b1110011100111;
    g_f = 13'b1000010000100;
    start(16'h0005, 5'd3, 4'd2);
    for (int k = 12; k >= 0; k--) expq.push_back({g_o[k], g_v[k], g_f[k], 1'b0, 1'b1, 1'b0});
    expq.push_back(DONE_E);
    expq.push_back(IDLE_E);
    drain();
    dut_sel = 0;

    // Reset while the third bit is on the line
    cur_name = "rst_mid";
    start(16'h00B5, 5'd8, 4'd0);
    push_bits(64'b101, 3, 8, 1'b0, 1'b0);
    drain();
    #2 rst = 1'b1;
    #1 check(cur_name, sample(), IDLE_E);
    @(negedge clk);
    rst = 1'b0;
    cur_name = "rst_after";
    repeat (3) expq.push_back(IDLE_E);
    drain();

    // Load attempt while busy, then abort on the fourth bit
    cur_name = "abort";
    start(16'h00B5, 5'd8, 4'd0);
    push_bits(64'b1011, 4, 8, 1'b0, 1'b0);
    step();
    step();
    lv0 = 1'b1; ld = 16'hFF00; ll = 5'd8;
    step();
    step();
    abort = 1'b1;
    repeat (3) expq.push_back(IDLE_E);
    drain();

    // Abort coinciding with a load in IDLE does not block the load
    cur_name = "abort_idle";
    start(16'h0006, 5'd3, 4'd0);
    abort = 1'b1;
    push_bits(64'b110, 3, 3, 1'b1, 1'b1);
    drain();

    // Second load issued in the done cycle of the first
    cur_name = "b2b";
    start(16'h000A, 5'd4, 4'd0);
    push_bits(64'b1010, 4, 4, 1'b1, 1'b0);
    drain();
    start(16'h0009, 5'd4, 4'd1);
    push_bits(64'b10011001, 8, 4, 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sequence_pattern_gen.md
Name: sequence_pattern_gen

Overview:
Serial bit-pattern transmitter, the stimulus-side counterpart of the Mealy sequence detector. It accepts a parallel pattern word, a length and a repeat count through a valid/ready load handshake. It then emits the pattern MSB-first, one bit per clock, on a single-bit line that drives the detector's `in` input. It supports optional idle gaps between repeats, abort, and a completion pulse, so detector benches and board demos can replay sequences without hand-written stimulus.

Parameters:
MAX_LEN, 16, width of pattern register; maximum bits per frame
LEN_W, 5, width of load_len (must hold MAX_LEN)
REP_W, 4, width of load_rep; frames sent = load_rep+1
GAP_CYCLES, 0, idle cycles (out=0, out_valid=0) inserted between consecutive repeats; 0 = back-to-back

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
load_valid  in  1  request to start a transmission
load_ready  out  1  block can accept a load; high only in IDLE
load_data  in  MAX_LEN  pattern; active bits are load_data[len-1:0]
load_len  in  LEN_W  number of bits per frame
load_rep  in  REP_W  extra repeats
abort  in  1  synchronous cancel of the current transmission
out  out  1  serial bit to detector
out_valid  out  1  out carries a pattern bit this cycle
frame_start  out  1  high with the first bit of each frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last bit of the last frame

Behaviour:
- States: IDLE, SHIFT, GAP. Encodings are in the package.
- Reset (async, rst=1):
  - State goes to IDLE.
  - out, out_valid, frame_start, done and busy go to 0; load_ready goes to 1.
  - Pattern register and counters are cleared.
  - Takes effect immediately, including mid-frame. No done pulse is produced.
- All outputs except load_ready are registered. load_ready = (state==IDLE), combinational from state.
- Accept: load_valid && load_ready at edge E0.
  - Latch data, len_eff and rep.
  - len_eff = min(load_len, MAX_LEN). load_len > MAX_LEN clamps to MAX_LEN.
  - load_valid while busy is ignored and has no effect.
- Latency:
  - The cycle after E0 carries out=data[len_eff-1], out_valid=1, frame_start=1.
  - Each subsequent cycle carries the next lower bit.
  - Bit data[0] appears len_eff cycles after E0.
- Frame end with repeats remaining:
  - GAP_CYCLES>0: enter GAP for exactly GAP_CYCLES cycles (out=0, out_valid=0), then restart the frame at data[len_eff-1] with frame_start=1.
  - GAP_CYCLES=0: data[len_eff-1] follows data[0] in the very next cycle, with frame_start=1.
- Frame end, last frame: next cycle state=IDLE, done=1, out_valid=0, out=0.
  - A load accepted in that done cycle starts a new frame in the following cycle, so streams run back-to-back with no dead cycle beyond done.
- load_len=0: accepted; no bits and no frame_start; done=1 in the cycle after E0. load_rep is ignored.
- abort=1 in SHIFT or GAP: next cycle state=IDLE, out_valid=0, no done pulse. abort in IDLE is ignored.
  - abort and load_valid in the same IDLE cycle: the load is accepted (abort has no effect in IDLE).
- Counters:
  - bit index counts down from len_eff-1 to 0 (LEN_W bits).
  - gap counter counts down from GAP_CYCLES-1 to 0.
  - rep counter counts down to 0.
  - No wrap-around is permitted; each counter reloads on transition.
- out is 0 whenever out_valid=0.

Decomposition:
- Shared package sequence_gen_pkg holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, GAP=2'd2;
  - the default widths;
  - a clamp function for len_eff.
- One natural sub-module: seq_down_counter, a loadable down-counter with a zero flag. It is instantiated for the bit index, gap and repeat counts.

Test Plan:
1. Reset mid-frame: load 8-bit pattern; assert rst at bit 3 -> out, out_valid, busy and done are 0 within the same cycle; load_ready=1; no done after rst releases.
2. load_data=16'h00B5, len=8, rep=0 -> out sequence 1,0,1,1,0,1,0,1 on cycles E0+1..E0+8 with out_valid=1; frame_start only at E0+1; done=1 at E0+9 only.
3. GAP_CYCLES=2, data=3'b101, len=3, rep=2 -> out 1,0,1,0,0,1,0,1,0,0,1,0,1; out_valid 1,1,1,0,0 repeating; frame_start 3 times; done once at E0+14.
4. len=0 -> no out_valid and no frame_start; done at E0+1. Then len=20 with MAX_LEN=16 -> exactly 16 bits, starting at load_data[15].
5. Abort at the 4th bit of len=8 -> out_valid=0 next cycle; no done; load_ready=1. load_valid asserted during busy beforehand -> ignored (pattern unchanged).
6. Back-to-back: a second load asserted in the done cycle of a first len=4 load -> the second frame's first bit appears the next cycle; done pulses once per load.
